// File: rtl/hram_pkg.sv
// Shared HyperRAM frame-readback definitions: FSM encoding, burst sizing, pixel order.
// Combinational helpers only; no latency, no flow control.
package hram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_ISSUE,
        ST_RECV,
        ST_FINISH
    } state_t;

    localparam int HRAM_BURST_DWORDS = 8;

    // 1: a dword leaves as rd_d[15:0] then rd_d[31:16].
    localparam logic PIX_LO_FIRST = 1'b1;

    // Capture-path read command as presented to hyper_xface.
    typedef struct packed {
        logic [31:0] addr;
        logic [5:0]  num_dwords;
    } rd_cmd_t;

    function automatic logic [5:0] burst_len(input logic [23:0] remaining, input int burst);
        return (remaining < 24'(burst)) ? remaining[5:0] : 6'(burst);
    endfunction

endpackage

// File: rtl/hram_rd_fifo.sv
// Synchronous show-ahead dword FIFO; dout valid whenever !empty, one cycle push-to-pop.
// Push while full and pop while empty are dropped; the caller reserves space upstream.
module hram_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hram_frame_reader.sv
// Reads a frame from HyperRAM in bursts and streams it as 16-bit pixels, low half first.
// Registered pixel output holds under pix_ready=0; bursts issue only once FIFO space is reserved.
module hram_frame_reader
    import hram_pkg::*;
#(
    parameter int BURST_DWORDS = HRAM_BURST_DWORDS,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [23:0] num_dwords,
    output logic        active,
    output logic        done,
    output logic        err,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [5:0]  rd_num_dwords,
    input  logic [31:0] rd_d,
    input  logic        rd_rdy,
    input  logic        busy,
    output logic [15:0] pix_d,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cur_addr;
    logic [23:0] remaining;
    logic [5:0]  blen;
    logic [5:0]  recv_cnt;
    logic [CW:0] fifo_count;
    logic [CW:0] free_slots;
    logic [31:0] fifo_dout;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] hi_hold;
    logic        half_pend;
    logic        start_ok;
    logic        space_ok;
    logic        last_word;
    logic        out_load;
    logic        pix_drained;
    logic        issue_now;
    logic        finish_now;

    assign blen        = burst_len(remaining, BURST_DWORDS);
    assign free_slots  = DEPTH_W - fifo_count;
    assign space_ok    = 32'(free_slots) >= 32'(blen);
    // start is blocked during the done cycle so back-to-back frames need a fresh pulse.
    assign start_ok    = start && !done;
    assign fifo_push   = (state == ST_RECV) && rd_rdy;
    assign last_word   = fifo_push && (recv_cnt == rd_num_dwords - 6'd1);
    assign out_load    = !pix_valid || pix_ready;
    assign fifo_pop    = out_load && !half_pend && !fifo_empty;
    assign pix_drained = fifo_empty && !half_pend && out_load;
    assign issue_now   = (state == ST_WAIT_SPACE) && (state_nxt == ST_ISSUE);
    assign finish_now  = (state == ST_FINISH) && (state_nxt == ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (start_ok) state_nxt = (num_dwords == '0) ? ST_FINISH : ST_WAIT_SPACE;
            ST_WAIT_SPACE: if (!busy && space_ok) state_nxt = ST_ISSUE;
            ST_ISSUE:      state_nxt = ST_RECV;
            ST_RECV:       if (last_word) state_nxt = (remaining == 24'(rd_num_dwords)) ? ST_FINISH : ST_WAIT_SPACE;
            ST_FINISH:     if (pix_drained) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            active        <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rd_req        <= 1'b0;
            rd_addr       <= '0;
            rd_num_dwords <= '0;
            cur_addr      <= '0;
            remaining     <= '0;
            recv_cnt      <= '0;
        end else begin
            state  <= state_nxt;
            done   <= finish_now;
            rd_req <= issue_now;
            if ((state == ST_IDLE) && start_ok) begin
                cur_addr  <= base_addr;
                remaining <= num_dwords;
                active    <= 1'b1;
                err       <= 1'b0;
            end else if (rd_rdy && (state != ST_RECV)) begin
                err <= 1'b1;
            end
            if (issue_now) begin
                rd_addr       <= cur_addr;
                rd_num_dwords <= blen;
                recv_cnt      <= '0;
            end else if (fifo_push) begin
                recv_cnt <= recv_cnt + 6'd1;
            end
            if (last_word) begin
                cur_addr  <= cur_addr + 32'(rd_num_dwords);
                remaining <= remaining - 24'(rd_num_dwords);
            end
            if (finish_now) active <= 1'b0;
        end
    end

    // Output stage: one pixel register plus the pending second half of the current dword.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_valid <= 1'b0;
            pix_d     <= '0;
            hi_hold   <= '0;
            half_pend <= 1'b0;
        end else if (out_load) begin
            if (half_pend) begin
                pix_d     <= hi_hold;
                pix_valid <= 1'b1;
                half_pend <= 1'b0;
            end else if (!fifo_empty) begin
                pix_d     <= PIX_LO_FIRST ? fifo_dout[15:0]  : fifo_dout[31:16];
                hi_hold   <= PIX_LO_FIRST ? fifo_dout[31:16] : fifo_dout[15:0];
                half_pend <= 1'b1;
                pix_valid <= 1'b1;
            end else begin
                pix_valid <= 1'b0;
            end
        end
    end

    hram_rd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (rd_d),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule
